// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: FSM state encoding and the ALU op code map.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // OP_SET and OP_SHIFT are the base codes of 4-wide groups (4-7 and 8-11).
    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_XOR     = 4'd2,
        OP_AND     = 4'd3,
        OP_SET     = 4'd4,
        OP_SHIFT   = 4'd8,
        OP_ANDN    = 4'd12,
        OP_SLB     = 4'd13,
        OP_BTR     = 4'd14,
        OP_ILLEGAL = 4'd15
    } alu_op_t;

endpackage

// File: rtl/alu_sequencer_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the pointer register lives in the caller.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic grant0,
    output logic grant1
);

    // A lone requester always wins; on contention rr_ptr names the preferred port.
    assign grant0 = valid0 & (~valid1 | ~rr_ptr);
    assign grant1 = valid1 & (~valid0 |  rr_ptr);

endmodule

// File: rtl/alu_sequencer.sv
// Shares one single-cycle ALU between two requesters: arbitrate, hold the ALU inputs
// for ALU_LAT cycles, capture result/zero and return them on a tagged response channel.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_data1,
    input  logic [WIDTH-1:0] req0_data2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_data1,
    input  logic [WIDTH-1:0] req1_data2,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(ALU_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic             rr_ptr;
    logic [CW-1:0]    counter;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             handshake;
    logic             sel_id;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_data1;
    logic [WIDTH-1:0] sel_data2;
    logic             sel_illegal;

    rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr_ptr (rr_ptr),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Ready is gated by rst_n so every output reads 0 while reset is held.
    assign req0_ready = rst_n & (state == S_IDLE) & grant0;
    assign req1_ready = rst_n & (state == S_IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;

    assign sel_id      = grant1;
    assign sel_op      = grant1 ? req1_op    : req0_op;
    assign sel_data1   = grant1 ? req1_data1 : req0_data1;
    assign sel_data2   = grant1 ? req1_data2 : req0_data2;
    assign sel_illegal = (sel_op == OPW'(OP_ILLEGAL));

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign handshake = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = sel_illegal ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (counter == '0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The ALU input registers double as the latched operands; an illegal op never
    // loads them, so the ALU keeps seeing the previous legal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            counter    <= '0;
            alu_op     <= '0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                rsp_id  <= sel_id;
                rsp_err <= sel_illegal;
                if (sel_illegal) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                end else begin
                    alu_op    <= sel_op;
                    alu_data1 <= sel_data1;
                    alu_data2 <= sel_data2;
                    counter   <= LAT_LOAD;
                end
            end
            if (state == S_EXEC) begin
                if (counter == '0) begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                end else begin
                    counter <= counter - CW'(1);
                end
            end
            if (handshake) begin
                rr_ptr <= ~rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios then random traffic on an ALU_LAT=1 and an
// ALU_LAT=3 instance, each checked against a transaction-level reference model.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n      [2];
    logic        req0_valid [2];
    logic        req0_ready [2];
    logic [3:0]  req0_op    [2];
    logic [15:0] req0_data1 [2];
    logic [15:0] req0_data2 [2];
    logic        req1_valid [2];
    logic        req1_ready [2];
    logic [3:0]  req1_op    [2];
    logic [15:0] req1_data1 [2];
    logic [15:0] req1_data2 [2];
    logic [3:0]  alu_op     [2];
    logic [15:0] alu_data1  [2];
    logic [15:0] alu_data2  [2];
    logic [15:0] alu_result [2];
    logic        alu_zero   [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic        rsp_id     [2];
    logic [15:0] rsp_result [2];
    logic        rsp_zero   [2];
    logic        rsp_err    [2];
    logic        busy       [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: preferred port and the op last presented to the ALU.
    int          pref       [2];
    logic [3:0]  last_op    [2];
    logic [15:0] last_a     [2];
    logic [15:0] last_b     [2];

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:                alu_fn = a + b;
            4'd1:                alu_fn = a - b;
            4'd2:                alu_fn = a ^ b;
            4'd3:                alu_fn = a & b;
            4'd4, 4'd5, 4'd6, 4'd7:     alu_fn = a | b;
            4'd8, 4'd9, 4'd10, 4'd11:   alu_fn = a << b[3:0];
            4'd12:               alu_fn = a & ~b;
            4'd13:               alu_fn = {a[7:0], b[7:0]};
            4'd14:               alu_fn = a >> b[3:0];
            default:             alu_fn = 16'h0;
        endcase
    endfunction

    assign alu_result[0] = alu_fn(alu_op[0], alu_data1[0], alu_data2[0]);
    assign alu_zero[0]   = (alu_result[0] == 16'h0);
    assign alu_result[1] = alu_fn(alu_op[1], alu_data1[1], alu_data2[1]);
    assign alu_zero[1]   = (alu_result[1] == 16'h0);

    alu_sequencer #(.WIDTH(16), .OPW(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n[0]),
        .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]), .req0_op(req0_op[0]),
        .req0_data1(req0_data1[0]), .req0_data2(req0_data2[0]),
        .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]), .req1_op(req1_op[0]),
        .req1_data1(req1_data1[0]), .req1_data2(req1_data2[0]),
        .alu_op(alu_op[0]), .alu_data1(alu_data1[0]), .alu_data2(alu_data2[0]),
        .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]),
        .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0])
    );

    alu_sequencer #(.WIDTH(16), .OPW(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]), .req0_op(req0_op[1]),
        .req0_data1(req0_data1[1]), .req0_data2(req0_data2[1]),
        .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]), .req1_op(req1_op[1]),
        .req1_data1(req1_data1[1]), .req1_data2(req1_data2[1]),
        .alu_op(alu_op[1]), .alu_data1(alu_data1[1]), .alu_data2(alu_data2[1]),
        .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]),
        .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int inst, input logic v0, input logic v1,
                                  input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                                  input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1);
        req0_valid[inst] = v0;
        req0_op[inst]    = op0;
        req0_data1[inst] = a0;
        req0_data2[inst] = b0;
        req1_valid[inst] = v1;
        req1_op[inst]    = op1;
        req1_data1[inst] = a1;
        req1_data2[inst] = b1;
    endtask

    task automatic check_all_zero(input int inst, input string tag);
        check_output({tag, "_ready0"}, {31'b0, req0_ready[inst]}, 0);
        check_output({tag, "_ready1"}, {31'b0, req1_ready[inst]}, 0);
        check_output({tag, "_alu_op"}, {28'b0, alu_op[inst]}, 0);
        check_output({tag, "_alu_d1"}, {16'b0, alu_data1[inst]}, 0);
        check_output({tag, "_alu_d2"}, {16'b0, alu_data2[inst]}, 0);
        check_output({tag, "_rsp_valid"}, {31'b0, rsp_valid[inst]}, 0);
        check_output({tag, "_rsp_id"}, {31'b0, rsp_id[inst]}, 0);
        check_output({tag, "_rsp_result"}, {16'b0, rsp_result[inst]}, 0);
        check_output({tag, "_rsp_zero"}, {31'b0, rsp_zero[inst]}, 0);
        check_output({tag, "_rsp_err"}, {31'b0, rsp_err[inst]}, 0);
        check_output({tag, "_busy"}, {31'b0, busy[inst]}, 0);
    endtask

    // One full transaction from offer to handshake; every expectation comes from the
    // model: grant from the preferred port, latency from the op legality and ALU_LAT.
    task automatic run_op(input int inst, input logic v0, input logic v1,
                          input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                          input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                          input int stall);
        int          g;
        int          lat;
        int          resp_at;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_zero;
        logic        illegal;
        logic        loser_valid;
        g       = (v0 && v1) ? pref[inst] : (v0 ? 0 : 1);
        op      = (g == 1) ? op1 : op0;
        a       = (g == 1) ? a1  : a0;
        b       = (g == 1) ? b1  : b0;
        illegal = (op == 4'd15);
        lat     = (inst == 0) ? 1 : 3;
        resp_at = illegal ? 1 : lat + 1;
        exp_res  = illegal ? 16'h0 : alu_fn(op, a, b);
        exp_zero = illegal ? 1'b0 : (exp_res == 16'h0);
        loser_valid = (g == 1) ? v0 : v1;

        @(negedge clk);
        apply_stimulus(inst, v0, v1, op0, a0, b0, op1, a1, b1);
        #1;
        check_output("ready0", {31'b0, req0_ready[inst]}, {31'b0, (g == 0)});
        check_output("ready1", {31'b0, req1_ready[inst]}, {31'b0, (g == 1)});
        @(posedge clk);
        #1;
        if (g == 1) req1_valid[inst] = 1'b0;
        else        req0_valid[inst] = 1'b0;
        if (!illegal) begin
            last_op[inst] = op;
            last_a[inst]  = a;
            last_b[inst]  = b;
        end

        for (int k = 1; k <= resp_at; k++) begin
            @(negedge clk);
            rsp_ready[inst] = (k == resp_at) ? (stall == 0) : 1'($urandom_range(0, 1));
            check_output("rsp_valid_timing", {31'b0, rsp_valid[inst]}, {31'b0, (k == resp_at)});
            check_output("busy_op", {31'b0, busy[inst]}, 1);
            check_output("ready0_busy", {31'b0, req0_ready[inst]}, 0);
            check_output("ready1_busy", {31'b0, req1_ready[inst]}, 0);
            check_output("alu_op", {28'b0, alu_op[inst]}, {28'b0, last_op[inst]});
            check_output("alu_d1", {16'b0, alu_data1[inst]}, {16'b0, last_a[inst]});
            check_output("alu_d2", {16'b0, alu_data2[inst]}, {16'b0, last_b[inst]});
        end

        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(negedge clk);
                rsp_ready[inst] = (s == stall);
                check_output("rsp_valid_hold", {31'b0, rsp_valid[inst]}, 1);
                check_output("busy_hold", {31'b0, busy[inst]}, 1);
                check_output("ready0_hold", {31'b0, req0_ready[inst]}, 0);
                check_output("ready1_hold", {31'b0, req1_ready[inst]}, 0);
            end
            check_output("rsp_id", {31'b0, rsp_id[inst]}, g);
            check_output("rsp_result", {16'b0, rsp_result[inst]}, {16'b0, exp_res});
            check_output("rsp_zero", {31'b0, rsp_zero[inst]}, {31'b0, exp_zero});
            check_output("rsp_err", {31'b0, rsp_err[inst]}, {31'b0, illegal});
        end

        @(negedge clk);
        rsp_ready[inst] = 1'b0;
        pref[inst] = 1 - g;
        #1;
        check_output("rsp_valid_after", {31'b0, rsp_valid[inst]}, 0);
        check_output("busy_after", {31'b0, busy[inst]}, 0);
        if (g == 1) check_output("loser0_ready", {31'b0, req0_ready[inst]}, {31'b0, loser_valid});
        else        check_output("loser1_ready", {31'b0, req1_ready[inst]}, {31'b0, loser_valid});
        req0_valid[inst] = 1'b0;
        req1_valid[inst] = 1'b0;
    endtask

    task automatic reset_model(input int inst);
        pref[inst]    = 0;
        last_op[inst] = 4'h0;
        last_a[inst]  = 16'h0;
        last_b[inst]  = 16'h0;
    endtask

    task automatic random_ops(input int inst, input int count);
        logic        v0;
        logic        v1;
        logic [3:0]  op0;
        logic [3:0]  op1;
        for (int n = 0; n < count; n++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op0 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            op1 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            run_op(inst, v0, v1, op0, 16'($urandom), 16'($urandom),
                   op1, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            rsp_ready[i] = 1'b0;
            apply_stimulus(i, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 16'h0, 16'h0);
            reset_model(i);
        end
        #12;
        check_all_zero(0, "reset");
        check_all_zero(1, "reset3");
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        $display("[TB] contention from reset alternates 0,1,0,1");
        for (int n = 0; n < 4; n++) begin
            run_op(0, 1'b1, 1'b1, 4'd2, 16'($urandom), 16'($urandom), 4'd3, 16'($urandom), 16'($urandom), 0);
        end

        $display("[TB] lone req0 add 3+4");
        run_op(0, 1'b1, 1'b0, 4'd0, 16'd3, 16'd4, 4'd0, 16'd0, 16'd0, 0);

        $display("[TB] req1 sub 5-5 with stalled consumer, req0 waiting");
        run_op(0, 1'b1, 1'b1, 4'd0, 16'd9, 16'd9, 4'd1, 16'd5, 16'd5, 3);

        $display("[TB] illegal op on req0");
        run_op(0, 1'b1, 1'b0, 4'd15, 16'h1234, 16'h5678, 4'd0, 16'd0, 16'd0, 1);

        $display("[TB] ALU_LAT=3 instance");
        run_op(1, 1'b1, 1'b0, 4'd0, 16'd100, 16'd23, 4'd0, 16'd0, 16'd0, 0);
        run_op(1, 1'b1, 1'b1, 4'd12, 16'hff0f, 16'h0f0f, 4'd13, 16'h1234, 16'h5678, 2);

        $display("[TB] reset in the middle of EXEC");
        @(negedge clk);
        apply_stimulus(0, 1'b1, 1'b0, 4'd0, 16'd1, 16'd2, 4'd0, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        req1_valid[0] = 1'b1;
        #3;
        rst_n[0] = 1'b0;
        #1;
        check_all_zero(0, "midreset");
        reset_model(0);
        @(negedge clk);
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;
        rst_n[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rsp_ready[0] = 1'b1;
            check_output("no_rsp_after_reset", {31'b0, rsp_valid[0]}, 0);
        end
        rsp_ready[0] = 1'b0;
        run_op(0, 1'b1, 1'b1, 4'd0, 16'd7, 16'd8, 4'd2, 16'd7, 16'd8, 0);

        $display("[TB] random traffic");
        random_ops(0, 40);
        random_ops(1, 25);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
